spi_command_port: RTL and testbench

SPI-slave front end for the command path of the DSP engine. It deserialises host MOSI traffic into 8-bit command bytes for the engine's command FIFO (`command_in` / `command_in_valid`). It also serialises the engine's 8-bit readback byte onto MISO. All SPI pins are asynchronous to `clk` and are oversampled. The block sits between the board SPI pins and the engine's command input, and drops bytes instead of overflowing the FIFO.

---
 rtl/spi_command_port_if.sv | 26 ++
 rtl/spi_command_port.sv | 117 +++++++++++
 tb/tb_spi_command_port.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_command_port_if.sv
// spi_command_port_if: SPI pins plus engine command/readback signals of the SPI command port
interface spi_command_port_if #(
    parameter int spi_fifo_length = 32
);
    localparam int CW = $clog2(spi_fifo_length) + 1;
    logic          sck;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [7:0]    tx_byte;
    logic [CW-1:0] fifo_count;
    logic [7:0]    command_out;
    logic          command_out_valid;
    logic          busy;
    logic          overrun;
    logic          frame_error;
    logic [15:0]   bytes_received;
    modport slave (
        input  sck, cs_n, mosi, tx_byte, fifo_count,
        output miso, command_out, command_out_valid, busy, overrun, frame_error, bytes_received
    );
    modport master (
        output sck, cs_n, mosi, tx_byte, fifo_count,
        input  miso, command_out, command_out_valid, busy, overrun, frame_error, bytes_received
    );
endinterface

// File: rtl/spi_command_port.sv
// spi_command_port: oversampled mode-0 SPI slave turning MOSI bytes into engine commands and serialising readback on MISO
module spi_command_port #(
    parameter int spi_fifo_length = 32,
    parameter int sync_stages     = 2
) (
    input logic               clk,
    input logic               rst_n,
    spi_command_port_if.slave bus
);
    localparam int CW = $clog2(spi_fifo_length) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(spi_fifo_length);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [sync_stages-1:0] sck_q, cs_q, mosi_q, live_q;
    logic       sck_prev_q, cs_prev_q, armed_q, seen_rise_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q, tx_q, cmd_q;
    logic       valid_q, overrun_q, frame_err_q;
    logic [15:0] bytes_q;
    logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall, start, stop;
    logic [7:0] rx_byte;

    assign sck_s    = sck_q[sync_stages-1];
    assign cs_s     = cs_q[sync_stages-1];
    assign mosi_s   = mosi_q[sync_stages-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    // armed_q blocks a cs_n that was already low at reset release from looking like a fresh falling edge
    assign start    = state_q == IDLE && cs_fall && armed_q;
    assign stop     = state_q == ACTIVE && cs_rise;
    assign rx_byte  = {rx_q[6:0], mosi_s};

    // Synchronise the pins, keep a delayed copy for edge detection, arm once a real cs_n high is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= '0;
            cs_q       <= '1;
            mosi_q     <= '0;
            live_q     <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            sck_q      <= {sck_q[sync_stages-2:0], bus.sck};
            cs_q       <= {cs_q[sync_stages-2:0], bus.cs_n};
            mosi_q     <= {mosi_q[sync_stages-2:0], bus.mosi};
            live_q     <= {live_q[sync_stages-2:0], 1'b1};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            armed_q    <= armed_q | (live_q[sync_stages-1] & cs_s);
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: cs_n falling edge opens a frame, rising edge closes it
    always_comb begin
        state_d = start ? ACTIVE : stop ? IDLE : state_q;
    end

    // Frame datapath: shift in on sck rise, shift out on sck fall; a cs_n rise masks any same-cycle sck edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            bytes_q     <= '0;
            seen_rise_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                bit_cnt_q   <= '0;
                tx_q        <= bus.tx_byte;
                seen_rise_q <= 1'b0;
            end else if (stop) begin
                bit_cnt_q <= '0;
                if (bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
            end else if (state_q == ACTIVE && sck_rise) begin
                rx_q        <= rx_byte;
                bit_cnt_q   <= bit_cnt_q + 3'd1;
                seen_rise_q <= 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    if (bus.fifo_count < FIFO_FULL) begin
                        cmd_q   <= rx_byte;
                        valid_q <= 1'b1;
                        bytes_q <= bytes_q + 16'd1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
            end else if (state_q == ACTIVE && sck_fall && seen_rise_q) begin
                tx_q <= bit_cnt_q == 3'd0 ? bus.tx_byte : {tx_q[6:0], 1'b0};
            end
        end
    end

    // Outputs; MISO is held low outside a frame
    always_comb begin
        bus.miso              = state_q == ACTIVE && tx_q[7];
        bus.busy              = state_q == ACTIVE;
        bus.command_out       = cmd_q;
        bus.command_out_valid = valid_q;
        bus.overrun           = overrun_q;
        bus.frame_error       = frame_err_q;
        bus.bytes_received    = bytes_q;
    end
endmodule

// File: tb/tb_spi_command_port.sv
// tb_spi_command_port: directed SPI host driving the command port and checking strobes, MISO and flags
module tb_spi_command_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;
    int   double_v = 0;
    logic prev_v = 1'b0;
    logic [7:0] last_cmd = 8'h00;
    logic [15:0] exp_bytes = 16'd0;

    spi_command_port_if #(.spi_fifo_length(32)) bus ();

    spi_command_port #(.spi_fifo_length(32), .sync_stages(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Strobe monitor sampled on the falling clock edge
    always @(negedge clk) begin
        if (bus.command_out_valid === 1'b1) begin
            strobes++;
            last_cmd = bus.command_out;
            if (prev_v === 1'b1) double_v++;
        end
        prev_v = bus.command_out_valid;
    end

    task automatic cs_low();
        bus.cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        bus.cs_n = 1'b1;
        #100;
    endtask

    // Mode-0 host: data set while sck low, MISO sampled just before the rising edge
    task automatic shift_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.mosi = mo[7-i];
            #40;
            mi = {mi[6:0], bus.miso};
            bus.sck = 1'b1;
            #40;
            bus.sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        #20;
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
        checks++; if (bus.command_out !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", bus.command_out); end
        checks++; if ({bus.command_out_valid, bus.busy, bus.overrun, bus.frame_error} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.command_out_valid, bus.busy, bus.overrun, bus.frame_error}); end
        checks++; if (bus.bytes_received !== 16'd0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", bus.bytes_received); end
        rst_n = 1'b1;
        #100;
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int s0;
        s0 = strobes;
        bus.tx_byte = 8'hA5;
        cs_low();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        shift_bits(8, 8'h3C, mi);
        cs_high();
        exp_bytes = exp_bytes + 16'd1;
        checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobes - s0); end
        checks++; if (last_cmd !== 8'h3C) begin errors++; $display("FAIL single_cmd: got %h want 3c", last_cmd); end
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h want a5", mi); end
        checks++; if (bus.bytes_received !== exp_bytes) begin errors++; $display("FAIL single_bytes: got %0d want %0d", bus.bytes_received, exp_bytes); end
        checks++; if ({bus.overrun, bus.frame_error, bus.busy, bus.miso} !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b want 0000", {bus.overrun, bus.frame_error, bus.busy, bus.miso}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1, m2, c0, c1, c2;
        int s0;
        s0 = strobes;
        bus.tx_byte = 8'hA5;
        cs_low();
        shift_bits(8, 8'h01, m0);
        c0 = last_cmd;
        bus.tx_byte = 8'h5A;
        shift_bits(8, 8'hFF, m1);
        c1 = last_cmd;
        shift_bits(8, 8'h80, m2);
        c2 = last_cmd;
        cs_high();
        exp_bytes = exp_bytes + 16'd3;
        checks++; if (strobes - s0 !== 3) begin errors++; $display("FAIL b2b_strobes: got %0d want 3", strobes - s0); end
        checks++; if ({c0, c1, c2} !== 24'h01FF80) begin errors++; $display("FAIL b2b_cmds: got %h want 01ff80", {c0, c1, c2}); end
        checks++; if ({m0, m1, m2} !== 24'hA55A5A) begin errors++; $display("FAIL b2b_miso: got %h want a55a5a", {m0, m1, m2}); end
        checks++; if (bus.bytes_received !== exp_bytes) begin errors++; $display("FAIL b2b_bytes: got %0d want %0d", bus.bytes_received, exp_bytes); end
    endtask

    task automatic test_full_fifo();
        logic [7:0] mi;
        int s0;
        s0 = strobes;
        bus.fifo_count = 6'd32;
        cs_low();
        shift_bits(8, 8'h77, mi);
        cs_high();
        checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL full_strobes: got %0d want 0", strobes - s0); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL full_overrun: got %b want 1", bus.overrun); end
        checks++; if (bus.command_out !== 8'h80) begin errors++; $display("FAIL full_cmd_held: got %h want 80", bus.command_out); end
        checks++; if (bus.bytes_received !== exp_bytes) begin errors++; $display("FAIL full_bytes: got %0d want %0d", bus.bytes_received, exp_bytes); end
        bus.fifo_count = 6'd31;
        s0 = strobes;
        cs_low();
        shift_bits(8, 8'h12, mi);
        cs_high();
        exp_bytes = exp_bytes + 16'd1;
        checks++; if (strobes - s0 !== 1 || last_cmd !== 8'h12) begin errors++; $display("FAIL room_strobe: got %0d x %h want 1 x 12", strobes - s0, last_cmd); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL room_overrun_sticky: got %b want 1", bus.overrun); end
        checks++; if (bus.bytes_received !== exp_bytes) begin errors++; $display("FAIL room_bytes: got %0d want %0d", bus.bytes_received, exp_bytes); end
        bus.fifo_count = 6'd0;
    endtask

    task automatic test_partial_frame();
        logic [7:0] mi;
        int s0;
        s0 = strobes;
        checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL partial_pre: got %b want 0", bus.frame_error); end
        cs_low();
        shift_bits(5, 8'hA8, mi);
        cs_high();
        checks++; if (bus.frame_error !== 1'b1) begin errors++; $display("FAIL partial_flag: got %b want 1", bus.frame_error); end
        checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL partial_strobes: got %0d want 0", strobes - s0); end
        cs_low();
        shift_bits(8, 8'hC3, mi);
        cs_high();
        exp_bytes = exp_bytes + 16'd1;
        checks++; if (strobes - s0 !== 1 || last_cmd !== 8'hC3) begin errors++; $display("FAIL partial_next: got %0d x %h want 1 x c3", strobes - s0, last_cmd); end
        checks++; if (bus.frame_error !== 1'b1) begin errors++; $display("FAIL partial_sticky: got %b want 1", bus.frame_error); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        int s0;
        bus.tx_byte = 8'hFF;
        cs_low();
        shift_bits(4, 8'hF0, mi);
        rst_n = 1'b0;
        #20;
        exp_bytes = 16'd0;
        checks++; if ({bus.miso, bus.command_out_valid, bus.busy, bus.overrun, bus.frame_error} !== 5'b00000) begin errors++; $display("FAIL rstmid_flags: got %b want 00000", {bus.miso, bus.command_out_valid, bus.busy, bus.overrun, bus.frame_error}); end
        checks++; if (bus.command_out !== 8'h00 || bus.bytes_received !== 16'd0) begin errors++; $display("FAIL rstmid_regs: got %h/%0d want 00/0", bus.command_out, bus.bytes_received); end
        rst_n = 1'b1;
        s0 = strobes;
        shift_bits(8, 8'h0F, mi);
        shift_bits(8, 8'h55, mi);
        checks++; if (strobes - s0 !== 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_ignored: got %0d strobes busy %b want 0 0", strobes - s0, bus.busy); end
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL rstmid_miso_idle: got %h want 00", mi); end
        cs_high();
        bus.tx_byte = 8'h96;
        cs_low();
        shift_bits(8, 8'h5E, mi);
        cs_high();
        exp_bytes = exp_bytes + 16'd1;
        checks++; if (strobes - s0 !== 1 || last_cmd !== 8'h5E) begin errors++; $display("FAIL rstmid_fresh: got %0d x %h want 1 x 5e", strobes - s0, last_cmd); end
        checks++; if (mi !== 8'h96 || bus.bytes_received !== exp_bytes) begin errors++; $display("FAIL rstmid_fresh_io: got %h/%0d want 96/%0d", mi, bus.bytes_received, exp_bytes); end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] mi;
        int s0;
        force dut.bytes_q = 16'hFFFF;
        #20;
        release dut.bytes_q;
        #20;
        s0 = strobes;
        cs_low();
        shift_bits(8, 8'h9A, mi);
        cs_high();
        checks++; if (strobes - s0 !== 1 || last_cmd !== 8'h9A) begin errors++; $display("FAIL wrap_strobe: got %0d x %h want 1 x 9a", strobes - s0, last_cmd); end
        checks++; if (bus.bytes_received !== 16'd0) begin errors++; $display("FAIL wrap_bytes: got %0d want 0", bus.bytes_received); end
    endtask

    initial begin
        bus.sck = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_byte = 8'h00;
        bus.fifo_count = 6'd0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_partial_frame();
        test_reset_mid_frame();
        test_counter_wrap();
        checks++; if (double_v !== 0) begin errors++; $display("FAIL strobe_consecutive: got %0d want 0", double_v); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
